spi_cmd_decoder: RTL and testbench
==================================

Name: spi_cmd_decoder

Overview:
Command decoder between the SPI slave's receive/transmit byte interface and the lab FSM. It consumes each received byte and turns step commands (0x00/0x01) into a valid/ready-handshaked input bit for the FSM. Query commands load a response byte into the SPI slave's TX path. It also counts protocol errors (unknown command, overrun, step timeout) and makes the count readable over SPI.

Parameters:
CMD_READ_STATE, 8'hFF, returns current FSM state byte
CMD_READ_ERR, 8'hFE, returns error counter
CMD_CLR_ERR, 8'hFD, clears error counter, returns ACK_CODE
ERR_CODE, 8'hEE, response byte for an unknown command
ACK_CODE, 8'hAC, response byte for CMD_CLR_ERR
STEP_TIMEOUT, 16, maximum cycles o_Step_Valid is held without i_Step_Ready (>=2)

Ports:
i_Clk  in  1  system clock (50 MHz)
i_Rst  in  1  synchronous reset, active-high
i_RX_DV  in  1  one-cycle pulse: i_RX_Byte valid
i_RX_Byte  in  8  received command byte
o_TX_DV  out  1  one-cycle pulse: load o_TX_Byte into SPI slave
o_TX_Byte  out  8  response byte
i_State  in  8  current FSM state
o_Step_Valid  out  1  step request to FSM
o_Step_Bit  out  1  FSM input bit, stable while o_Step_Valid
i_Step_Ready  in  1  FSM accepts step
o_Err_Cnt  out  8  saturating error count
o_Busy  out  1  high whenever state != S_IDLE
o_Overrun  out  1  one-cycle pulse: command dropped

Behaviour:
- One clock (i_Clk); synchronous active-high reset (i_Rst). All state updates on the rising edge of i_Clk.
- Reset: state S_IDLE. o_TX_DV, o_TX_Byte, o_Step_Valid, o_Step_Bit, o_Err_Cnt, o_Overrun, o_Busy all 0. Timeout counter 0.
- Reset mid-operation: aborts immediately. No TX_DV and no step handshake are issued afterwards.
- States: S_IDLE, S_DECODE, S_STEP, S_RESP.
- S_IDLE: if i_RX_DV, capture cmd_q <= i_RX_Byte and go to S_DECODE.
- S_DECODE (always exactly 1 cycle):
  - 8'h00/8'h01: o_Step_Bit <= cmd_q[0]; o_Step_Valid <= 1; clear timeout counter; go to S_STEP.
  - CMD_READ_STATE: o_TX_Byte <= i_State as sampled in this cycle; o_TX_DV <= 1; go to S_RESP.
  - CMD_READ_ERR: o_TX_Byte <= o_Err_Cnt (pre-update value); o_TX_DV <= 1; go to S_RESP.
  - CMD_CLR_ERR: err cleared; o_TX_Byte <= ACK_CODE; o_TX_DV <= 1; go to S_RESP.
  - Any other byte: err +1; o_TX_Byte <= ERR_CODE; o_TX_DV <= 1; go to S_RESP.
- S_RESP: o_TX_DV <= 0; go to S_IDLE.
  - RX_DV in cycle n gives o_TX_DV high in exactly cycle n+2.
  - o_TX_Byte holds its value until the next response.
- S_STEP:
  - o_Step_Valid and o_Step_Bit are held stable.
  - Handshake occurs at any edge where o_Step_Valid && i_Step_Ready. At that edge: o_Step_Valid <= 0 and go to S_IDLE.
  - Timeout counter increments on each cycle without ready. If valid has been held STEP_TIMEOUT cycles with no ready: o_Step_Valid <= 0, err +1, go to S_IDLE.
  - Ready arriving on the final timeout cycle counts as a handshake, not a timeout.
- Overrun: i_RX_DV while state != S_IDLE (including S_DECODE, S_RESP and the handshake cycle) drops the byte, pulses o_Overrun for one cycle, and adds err +1.
- Error counter arithmetic: 8-bit, saturates at 8'hFF and never wraps.
  - Events in the same cycle add together (overrun + timeout = +2, saturating).
  - CMD_CLR_ERR in the same cycle as an overrun: clear, then count, giving 1.
- Step commands produce no TX response.

Decomposition:
- Package spi_cmd_pkg holds:
  - command codes (CMD_READ_STATE, CMD_READ_ERR, CMD_CLR_ERR, step codes 8'h00/8'h01);
  - ERR_CODE and ACK_CODE;
  - state encoding S_IDLE..S_RESP.
- No sub-module is required. The saturating error accumulator may be written as an internal function.

Test Plan:
- Reset, then RX_DV with byte 8'hFF while i_State=8'h03 -> o_TX_DV high exactly 2 cycles later, o_TX_Byte=8'h03, o_Busy low after 3 cycles.
- Byte 8'h01 with i_Step_Ready tied high -> o_Step_Valid high for 1 cycle with o_Step_Bit=1; no o_TX_DV; o_Err_Cnt stays 0.
- Byte 8'h00 with i_Step_Ready held low -> o_Step_Valid high exactly 16 cycles, then drops; o_Err_Cnt=1. Ready asserted on cycle 16 instead -> handshake, o_Err_Cnt=0.
- Byte 8'h5A -> o_TX_Byte=8'hEE, o_Err_Cnt=1. Then 8'hFE -> o_TX_Byte=8'h01. Then 8'hFD -> o_TX_Byte=8'hAC, o_Err_Cnt=0.
- RX_DV on two consecutive cycles -> second byte dropped, o_Overrun pulses once, o_Err_Cnt=1, only one response issued.
- 260 unknown bytes spaced 4 cycles apart -> o_Err_Cnt saturates at 8'hFF. i_Rst asserted during S_STEP -> o_Step_Valid=0 and o_Err_Cnt=0 on the next cycle, no TX_DV.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared command codes, response codes and state encoding for the SPI command decoder.
// Also holds the saturating adder used by the protocol error counter.
package spi_cmd_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_STEP   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [7:0] CMD_STEP_0     = 8'h00;
    localparam logic [7:0] CMD_STEP_1     = 8'h01;
    localparam logic [7:0] CMD_READ_STATE = 8'hFF;
    localparam logic [7:0] CMD_READ_ERR   = 8'hFE;
    localparam logic [7:0] CMD_CLR_ERR    = 8'hFD;

    localparam logic [7:0] ERR_CODE = 8'hEE;
    localparam logic [7:0] ACK_CODE = 8'hAC;

    // Several error events can land in one cycle, so the increment is up to 2.
    function automatic logic [7:0] sat_add(input logic [7:0] base, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, base} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/spi_cmd_decoder.sv
// Decodes SPI command bytes into FSM step handshakes or TX responses,
// and keeps a saturating count of protocol errors.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int unsigned STEP_TIMEOUT = 16
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_TX_DV,
    output logic [7:0] o_TX_Byte,
    input  logic [7:0] i_State,
    output logic       o_Step_Valid,
    output logic       o_Step_Bit,
    input  logic       i_Step_Ready,
    output logic [7:0] o_Err_Cnt,
    output logic       o_Busy,
    output logic       o_Overrun
);

    localparam int unsigned TMO_W = (STEP_TIMEOUT > 2) ? $clog2(STEP_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(STEP_TIMEOUT - 1);

    state_t           state_q,      state_d;
    logic [7:0]       cmd_q,        cmd_d;
    logic             tx_dv_q,      tx_dv_d;
    logic [7:0]       tx_byte_q,    tx_byte_d;
    logic             step_valid_q, step_valid_d;
    logic             step_bit_q,   step_bit_d;
    logic [7:0]       err_cnt_q,    err_cnt_d;
    logic             overrun_q,    overrun_d;
    logic [TMO_W-1:0] tmo_cnt_q,    tmo_cnt_d;

    logic [1:0]       err_inc;
    logic             err_clr;

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        tx_dv_d      = 1'b0;
        tx_byte_d    = tx_byte_q;
        step_valid_d = step_valid_q;
        step_bit_d   = step_bit_q;
        overrun_d    = 1'b0;
        tmo_cnt_d    = tmo_cnt_q;
        err_inc      = 2'd0;
        err_clr      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_RX_DV) begin
                    cmd_d   = i_RX_Byte;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (cmd_q)
                    CMD_STEP_0, CMD_STEP_1: begin
                        step_bit_d   = cmd_q[0];
                        step_valid_d = 1'b1;
                        tmo_cnt_d    = '0;
                        state_d      = S_STEP;
                    end
                    CMD_READ_STATE: begin
                        tx_byte_d = i_State;
                        tx_dv_d   = 1'b1;
                        state_d   = S_RESP;
                    end
                    CMD_READ_ERR: begin
                        tx_byte_d = err_cnt_q;
                        tx_dv_d   = 1'b1;
                        state_d   = S_RESP;
                    end
                    CMD_CLR_ERR: begin
                        err_clr   = 1'b1;
                        tx_byte_d = ACK_CODE;
                        tx_dv_d   = 1'b1;
                        state_d   = S_RESP;
                    end
                    default: begin
                        err_inc   = err_inc + 2'd1;
                        tx_byte_d = ERR_CODE;
                        tx_dv_d   = 1'b1;
                        state_d   = S_RESP;
                    end
                endcase
            end
            S_STEP: begin
                // Ready on the last permitted cycle still wins over the timeout.
                if (step_valid_q && i_Step_Ready) begin
                    step_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    step_valid_d = 1'b0;
                    err_inc      = err_inc + 2'd1;
                    state_d      = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (i_RX_DV && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
            err_inc   = err_inc + 2'd1;
        end

        // Clear takes effect before any same-cycle errors are counted.
        err_cnt_d = sat_add(err_clr ? 8'h00 : err_cnt_q, err_inc);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q      <= S_IDLE;
            cmd_q        <= 8'h00;
            tx_dv_q      <= 1'b0;
            tx_byte_q    <= 8'h00;
            step_valid_q <= 1'b0;
            step_bit_q   <= 1'b0;
            err_cnt_q    <= 8'h00;
            overrun_q    <= 1'b0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            tx_dv_q      <= tx_dv_d;
            tx_byte_q    <= tx_byte_d;
            step_valid_q <= step_valid_d;
            step_bit_q   <= step_bit_d;
            err_cnt_q    <= err_cnt_d;
            overrun_q    <= overrun_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign o_TX_DV      = tx_dv_q;
    assign o_TX_Byte    = tx_byte_q;
    assign o_Step_Valid = step_valid_q;
    assign o_Step_Bit   = step_bit_q;
    assign o_Err_Cnt    = err_cnt_q;
    assign o_Overrun    = overrun_q;
    assign o_Busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed self-checking bench for spi_cmd_decoder with hand-computed expectations.
module tb_spi_cmd_decoder;

    logic       i_Clk;
    logic       i_Rst;
    logic       i_RX_DV;
    logic [7:0] i_RX_Byte;
    logic       o_TX_DV;
    logic [7:0] o_TX_Byte;
    logic [7:0] i_State;
    logic       o_Step_Valid;
    logic       o_Step_Bit;
    logic       i_Step_Ready;
    logic [7:0] o_Err_Cnt;
    logic       o_Busy;
    logic       o_Overrun;

    int checks = 0;
    int errors = 0;
    int tx_pulses = 0;
    int ovr_pulses = 0;
    int valid_cycles = 0;

    spi_cmd_decoder #(.STEP_TIMEOUT(16)) dut (
        .i_Clk       (i_Clk),
        .i_Rst       (i_Rst),
        .i_RX_DV     (i_RX_DV),
        .i_RX_Byte   (i_RX_Byte),
        .o_TX_DV     (o_TX_DV),
        .o_TX_Byte   (o_TX_Byte),
        .i_State     (i_State),
        .o_Step_Valid(o_Step_Valid),
        .o_Step_Bit  (o_Step_Bit),
        .i_Step_Ready(i_Step_Ready),
        .o_Err_Cnt   (o_Err_Cnt),
        .o_Busy      (o_Busy),
        .o_Overrun   (o_Overrun)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // Pulse/cycle counters sampled mid-cycle, away from the active edge.
    always @(negedge i_Clk) begin
        if (o_TX_DV)      tx_pulses    <= tx_pulses + 1;
        if (o_Overrun)    ovr_pulses   <= ovr_pulses + 1;
        if (o_Step_Valid) valid_cycles <= valid_cycles + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        i_RX_DV   = 1'b1;
        i_RX_Byte = b;
        tick();
        i_RX_DV   = 1'b0;
    endtask

    task automatic runQuery(input string tag, input logic [7:0] b, input int exp_tx);
        applyStimulus(b);
        checkOutput({tag, " dv_n+1"}, int'(o_TX_DV), 0);
        tick();
        checkOutput({tag, " dv_n+2"}, int'(o_TX_DV), 1);
        checkOutput({tag, " tx_byte"}, int'(o_TX_Byte), exp_tx);
        tick();
        checkOutput({tag, " dv_n+3"}, int'(o_TX_DV), 0);
        checkOutput({tag, " busy_done"}, int'(o_Busy), 0);
    endtask

    initial begin
        int tx_before;
        int valid_before;
        int ovr_before;
        int exp_err;

        i_Rst        = 1'b1;
        i_RX_DV      = 1'b0;
        i_RX_Byte    = 8'h00;
        i_State      = 8'h00;
        i_Step_Ready = 1'b0;
        tick();
        tick();
        checkOutput("rst tx_dv", int'(o_TX_DV), 0);
        checkOutput("rst tx_byte", int'(o_TX_Byte), 0);
        checkOutput("rst step_valid", int'(o_Step_Valid), 0);
        checkOutput("rst step_bit", int'(o_Step_Bit), 0);
        checkOutput("rst err_cnt", int'(o_Err_Cnt), 0);
        checkOutput("rst overrun", int'(o_Overrun), 0);
        checkOutput("rst busy", int'(o_Busy), 0);
        i_Rst = 1'b0;
        tick();

        // Read state: response two cycles after the RX strobe.
        i_State = 8'h03;
        runQuery("read_state", 8'hFF, 'h03);
        tick();
        checkOutput("tx_byte hold", int'(o_TX_Byte), 'h03);

        // Step 1 with ready already high: one valid cycle, no TX.
        tx_before    = tx_pulses;
        valid_before = valid_cycles;
        i_Step_Ready = 1'b1;
        applyStimulus(8'h01);
        checkOutput("step1 decode valid", int'(o_Step_Valid), 0);
        checkOutput("step1 decode busy", int'(o_Busy), 1);
        tick();
        checkOutput("step1 valid", int'(o_Step_Valid), 1);
        checkOutput("step1 bit", int'(o_Step_Bit), 1);
        tick();
        checkOutput("step1 valid drop", int'(o_Step_Valid), 0);
        checkOutput("step1 busy", int'(o_Busy), 0);
        tick();
        checkOutput("step1 valid cycles", valid_cycles - valid_before, 1);
        checkOutput("step1 no tx", tx_pulses - tx_before, 0);
        checkOutput("step1 err", int'(o_Err_Cnt), 0);
        i_Step_Ready = 1'b0;

        // Step 0 never accepted: times out after 16 valid cycles.
        valid_before = valid_cycles;
        applyStimulus(8'h00);
        tick();
        checkOutput("step0 bit", int'(o_Step_Bit), 0);
        for (int i = 0; i < 40; i++) begin
            if (!o_Busy) break;
            tick();
        end
        checkOutput("timeout busy", int'(o_Busy), 0);
        checkOutput("timeout valid", int'(o_Step_Valid), 0);
        tick();
        checkOutput("timeout valid cycles", valid_cycles - valid_before, 16);
        checkOutput("timeout err", int'(o_Err_Cnt), 1);

        runQuery("clr1", 8'hFD, 'hAC);
        checkOutput("clr1 err", int'(o_Err_Cnt), 0);

        // Ready arrives on the 16th valid cycle: handshake, no error.
        applyStimulus(8'h00);
        tick();
        for (int i = 0; i < 15; i++) tick();
        checkOutput("late valid still high", int'(o_Step_Valid), 1);
        i_Step_Ready = 1'b1;
        tick();
        i_Step_Ready = 1'b0;
        checkOutput("late handshake valid", int'(o_Step_Valid), 0);
        checkOutput("late handshake busy", int'(o_Busy), 0);
        checkOutput("late handshake err", int'(o_Err_Cnt), 0);

        // Unknown command, error readback, clear.
        runQuery("unknown", 8'h5A, 'hEE);
        checkOutput("unknown err", int'(o_Err_Cnt), 1);
        runQuery("read_err", 8'hFE, 'h01);
        runQuery("clr2", 8'hFD, 'hAC);
        checkOutput("clr2 err", int'(o_Err_Cnt), 0);

        // Back-to-back RX strobes: second dropped as overrun.
        tx_before  = tx_pulses;
        ovr_before = ovr_pulses;
        i_RX_DV    = 1'b1;
        i_RX_Byte  = 8'hFF;
        tick();
        i_RX_Byte  = 8'hFE;
        tick();
        i_RX_DV    = 1'b0;
        checkOutput("ovr pulse", int'(o_Overrun), 1);
        checkOutput("ovr tx_byte", int'(o_TX_Byte), 'h03);
        checkOutput("ovr err", int'(o_Err_Cnt), 1);
        tick();
        checkOutput("ovr pulse end", int'(o_Overrun), 0);
        tick();
        tick();
        checkOutput("ovr pulse count", ovr_pulses - ovr_before, 1);
        checkOutput("ovr tx count", tx_pulses - tx_before, 1);

        // 260 unknown bytes: counter climbs from 1 and sticks at 0xFF.
        exp_err = 1;
        for (int i = 0; i < 260; i++) begin
            applyStimulus(8'h5A);
            tick();
            tick();
            tick();
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            checkOutput($sformatf("sat err %0d", i), int'(o_Err_Cnt), exp_err);
        end
        checkOutput("sat final", int'(o_Err_Cnt), 'hFF);

        // Clear colliding with an overrun: clear first, then count one.
        i_RX_DV   = 1'b1;
        i_RX_Byte = 8'hFD;
        tick();
        tick();
        i_RX_DV   = 1'b0;
        checkOutput("clr+ovr err", int'(o_Err_Cnt), 1);
        checkOutput("clr+ovr tx_byte", int'(o_TX_Byte), 'hAC);
        tick();
        tick();

        // Reset while a step is pending aborts everything.
        applyStimulus(8'h01);
        tick();
        checkOutput("pre-rst valid", int'(o_Step_Valid), 1);
        i_Rst = 1'b1;
        tick();
        i_Rst = 1'b0;
        checkOutput("mid-rst valid", int'(o_Step_Valid), 0);
        checkOutput("mid-rst err", int'(o_Err_Cnt), 0);
        checkOutput("mid-rst busy", int'(o_Busy), 0);
        checkOutput("mid-rst tx_dv", int'(o_TX_DV), 0);
        tx_before    = tx_pulses;
        valid_before = valid_cycles;
        for (int i = 0; i < 20; i++) tick();
        checkOutput("post-rst no tx", tx_pulses - tx_before, 0);
        checkOutput("post-rst no valid", valid_cycles - valid_before, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
